// File: rtl/l2_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : l2_request_arbiter
// Brief    : Round-robin arbiter feeding one registered request slot into the
//            L2 reservation/atomic stage; returns per-port SC results.
// Revision : 1.0 - initial release
// ============================================================================
module l2_request_arbiter #(
  parameter int L2_NUM_PORTS = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [L2_NUM_PORTS-1:0]              req_valid,
  input  logic [L2_NUM_PORTS-1:0][29:0]        req_addr,
  input  logic [L2_NUM_PORTS-1:0]              req_lr,
  input  logic [L2_NUM_PORTS-1:0]              req_sc,
  input  logic [L2_NUM_PORTS-1:0]              req_store,
  output logic [L2_NUM_PORTS-1:0]              req_ready,
  output logic [29:0]                          out_addr,
  output logic [$clog2(L2_NUM_PORTS)-1:0]      out_id,
  output logic                                 out_lr,
  output logic                                 out_sc,
  output logic                                 out_store,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 strobe,
  input  logic                                 abort_request,
  output logic [L2_NUM_PORTS-1:0]              sc_result_valid,
  output logic                                 sc_success
);

  localparam int c_id_w  = $clog2(L2_NUM_PORTS);
  // One extra bit so ptr + offset never overflows before the modulo fold.
  localparam int c_sum_w = c_id_w + 1;

  logic [c_id_w-1:0]       r_ptr;
  logic                    r_valid;
  logic [29:0]             r_addr;
  logic [c_id_w-1:0]       r_id;
  logic                    r_lr;
  logic                    r_sc;
  logic                    r_store;
  logic [L2_NUM_PORTS-1:0] r_scv;
  logic                    r_scs;

  logic                    w_found;
  logic [c_id_w-1:0]       w_sel;
  logic [c_sum_w-1:0]      w_sum;
  logic                    w_free;
  logic                    w_grant;
  logic [c_id_w-1:0]       w_next_ptr;

  // The slot can take a new request when empty or being drained this cycle.
  assign w_free  = ~r_valid | out_ready;
  // Gating with rst keeps req_ready low for the whole reset window.
  assign w_grant = w_found & w_free & rst;
  assign strobe  = r_valid & out_ready;

  assign w_next_ptr = (w_sel == c_id_w'(L2_NUM_PORTS - 1)) ? '0 : w_sel + c_id_w'(1);

  // Search from the rr pointer upward, wrapping, for the first valid port.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    for (int i = 0; i < L2_NUM_PORTS; i++) begin
      w_sum = {1'b0, r_ptr} + c_sum_w'(i);
      if (w_sum >= c_sum_w'(L2_NUM_PORTS)) begin
        w_sum = w_sum - c_sum_w'(L2_NUM_PORTS);
      end
      if (!w_found && req_valid[w_sum[c_id_w-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_sum[c_id_w-1:0];
      end
    end
  end

  // One-hot ready at the selected port, only when the grant actually happens.
  always_comb begin
    req_ready = '0;
    if (w_grant) begin
      req_ready[w_sel] = 1'b1;
    end
  end

  // Output slot and rr pointer: load on grant, empty on drain without reload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_ptr   <= '0;
      r_addr  <= '0;
      r_id    <= '0;
      r_lr    <= 1'b0;
      r_sc    <= 1'b0;
      r_store <= 1'b0;
    end else if (w_grant) begin
      r_valid <= 1'b1;
      r_addr  <= req_addr[w_sel];
      r_id    <= w_sel;
      r_lr    <= req_lr[w_sel];
      r_sc    <= req_sc[w_sel];
      r_store <= req_store[w_sel];
      r_ptr   <= w_next_ptr;
    end else if (strobe) begin
      r_valid <= 1'b0;
    end
  end

  // SC completion pulse to the owning port; success level holds between SCs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scv <= '0;
      r_scs <= 1'b0;
    end else begin
      r_scv <= '0;
      if (strobe && r_sc) begin
        r_scv[r_id] <= 1'b1;
        r_scs       <= ~abort_request;
      end
    end
  end

  assign out_valid       = r_valid;
  assign out_addr        = r_addr;
  assign out_id          = r_id;
  assign out_lr          = r_lr;
  assign out_sc          = r_sc;
  assign out_store       = r_store;
  assign sc_result_valid = r_scv;
  assign sc_success      = r_scs;

endmodule
`default_nettype wire

// File: doc/l2_request_arbiter.md
Name: l2_request_arbiter

Overview:
Round-robin arbiter in front of the L2 reservation/atomic stage. It selects one request per cycle from L2_NUM_PORTS requesters and registers it into a single output slot. It drives the addr/id/strobe/lr/sc/store bundle consumed by the reservation logic. It samples that stage's abort_request to return a per-port store-conditional result.

Parameters:
L2_NUM_PORTS, 4, number of requesting ports (≥2); ID width is $clog2(L2_NUM_PORTS).

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-low reset.
req_valid  in  L2_NUM_PORTS  per-port request valid.
req_addr  in  L2_NUM_PORTS x 30  per-port word address [31:2].
req_lr  in  L2_NUM_PORTS  request is load-reserved.
req_sc  in  L2_NUM_PORTS  request is store-conditional.
req_store  in  L2_NUM_PORTS  request is a store or RMW AMO.
req_ready  out  L2_NUM_PORTS  one-hot grant; the request is taken this cycle.
out_addr  out  30  selected address to the reservation stage.
out_id  out  $clog2(L2_NUM_PORTS)  selected port id.
out_lr / out_sc / out_store  out  1 each  selected request type.
out_valid  out  1  output slot holds a request.
out_ready  in  1  downstream accepts the slot this cycle.
strobe  out  1  out_valid & out_ready; the reservation stage acts on this.
abort_request  in  1  from the reservation stage, valid in the strobe cycle.
sc_result_valid  out  L2_NUM_PORTS  one-cycle pulse to the port whose SC completed.
sc_success  out  1  1 = SC succeeded (no abort); qualified by sc_result_valid.

Behaviour:
- Reset (rst low, async): out_valid=0, rr pointer=0, sc_result_valid=0, sc_success=0, out_addr/out_id/out_* type bits=0. req_ready=0 while in reset.
- Slot free condition: free = ~out_valid | out_ready. Grant happens only when free.
- Selection: the lowest index ≥ rr pointer with req_valid=1, wrapping modulo L2_NUM_PORTS. req_ready is one-hot at that index and combinational from req_valid. It is all-zero if no request is valid or the slot is not free.
- On a grant to port k: the slot loads addr/id=k/lr/sc/store next edge; out_valid=1; rr pointer becomes (k+1) mod L2_NUM_PORTS (N-1 wraps to 0). The pointer is unchanged without a grant.
- If the slot is consumed (strobe) with no new grant, out_valid falls to 0 next edge.
- Back-to-back: consume and reload in the same cycle gives one request per cycle sustained throughput.
- Stall: while out_valid & ~out_ready, all slot fields are held stable and req_ready=0.
- Requesters must hold req_* stable until req_ready. The arbiter never drops or duplicates a request.
- Type bits: at most one of lr/sc/store is expected per request. The slot passes them through unchanged; there is no checking.
- SC result: when strobe & out_sc, the next edge sets sc_result_valid[out_id]=1 and sc_success=~abort_request. Otherwise sc_result_valid=0 next edge, and sc_success holds its last value.
- Latency: grant to out_valid is 1 cycle. Strobe of an SC to sc_result_valid is 1 cycle.
- Fairness: any continuously valid port is granted within L2_NUM_PORTS grants.
- Reset asserted mid-stall clears the slot; the held request is lost, and its requester sees no ready.

Test Plan:
- Reset then idle: all req_valid=0 for 10 cycles -> out_valid=0, strobe=0, req_ready=0 throughout.
- Rotation: ports 0-3 all valid, out_ready=1 -> grant order 0,1,2,3,0; out_id follows one cycle later; one strobe per cycle.
- Stall: port 2 granted with addr 0x1000, out_ready=0 for 3 cycles while port 1 is valid -> out_addr stays 0x1000, req_ready=0. When out_ready=1, strobe fires and port 1 is granted the same cycle.
- Wrap: pointer at 3, only port 3 valid -> granted, pointer becomes 0. Then ports 0 and 3 valid -> port 0 granted first.
- SC result: port 1 SC strobed with abort_request=0 -> next cycle sc_result_valid=4'b0010, sc_success=1. Port 2 SC with abort_request=1 -> 4'b0100, sc_success=0. Non-SC strobe -> no pulse.
- Async reset while out_valid=1 and stalled -> out_valid drops immediately without a clock edge. After release, the pointer restarts at 0.
